// File: rtl/apb_data_mem.sv
// apb_data_mem: APB slave word memory. It clears itself to zero after reset and can insert wait states.
// Each access is held off until the clear has finished.
module apb_data_mem #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_psel,
    input  logic                i_penable,
    input  logic                i_pwrite,
    input  logic [ADDR_W-1:0]   i_paddr,
    input  logic [DATA_W-1:0]   i_pwdata,
    input  logic [DATA_W/8-1:0] i_pstrb,
    output logic [DATA_W-1:0]   o_prdata,
    output logic                o_pready,
    output logic                o_pslverr,
    output logic                o_init_done
);
    localparam int BYTES = DATA_W / 8;
    localparam int IW = $clog2(DEPTH);
    localparam int LSB = $clog2(BYTES);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [IW-1:0]     clr_idx;
    logic [3:0]        cnt;
    logic              access;
    logic              addr_ok;
    logic [ADDR_W-1:0] off;
    logic [IW-1:0]     word;
    logic [DATA_W-1:0] merged;

    assign access   = i_psel && i_penable;
    assign off      = i_paddr - BASE_ADDR;
    assign addr_ok  = i_paddr >= BASE_ADDR && {1'b0, off} < SPAN && (off & ADDR_W'(BYTES - 1)) == '0;
    assign word     = off[LSB +: IW];
    assign o_pready = access && (state == DONE || (state == IDLE && WAIT_STATES == 0));
    assign o_pslverr = o_pready && !addr_ok;
    assign o_prdata = (o_pready && addr_ok && !i_pwrite) ? mem[word] : '0;

    always_comb begin
        merged = mem[word];
        for (int b = 0; b < BYTES; b++)
            merged[8*b +: 8] = i_pstrb[b] ? i_pwdata[8*b +: 8] : merged[8*b +: 8];
    end

    // Single write port: the clear owns it during INIT, and APB can only complete outside INIT.
    always_ff @(posedge i_clk)
        if (state == INIT && !i_reset)
            mem[clr_idx] <= '0;
        else if (o_pready && addr_ok && i_pwrite)
            mem[word] <= merged;

    // The IDLE cycle that sees the access counts as the first wait cycle.
    // After it, WAIT lasts WAIT_STATES-1 cycles, so o_pready appears on access cycle WAIT_STATES+1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= INIT;
            clr_idx     <= '0;
            cnt         <= '0;
            o_init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_idx <= clr_idx + IW'(1);
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state       <= IDLE;
                        o_init_done <= 1'b1;
                    end
                end
                IDLE:
                    if (access && WAIT_STATES != 0) begin
                        cnt   <= 4'(WAIT_STATES - 1);
                        state <= WAIT_STATES == 1 ? DONE : WAIT;
                    end
                WAIT:
                    if (!access) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt <= 4'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                DONE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: doc/apb_data_mem.md
APB_DATA_MEM -- requirements
Module: apb_data_mem

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, APB byte-address width.
REQ-003 Parameter DEPTH, default 4096, number of DATA_W words; power of two.
REQ-004 Parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 Parameter WAIT_STATES, default 0, extra ACCESS cycles before PREADY (0..15).
REQ-006 i_clk  in  1  clock, rising edge.
REQ-007 i_reset  in  1  reset, asynchronous, active-high.
REQ-008 i_psel  in  1  APB select.
REQ-009 i_penable  in  1  APB enable (access phase).
REQ-010 i_pwrite  in  1  1 = write, 0 = read.
REQ-011 i_paddr  in  ADDR_W  byte address.
REQ-012 i_pwdata  in  DATA_W  write data.
REQ-013 i_pstrb  in  DATA_W/8  byte write strobes; bit n enables bits [8n+7:8n].
REQ-014 o_prdata  out  DATA_W  read data, valid when o_pready=1.
REQ-015 o_pready  out  1  transfer completes this cycle.
REQ-016 o_pslverr  out  1  error response, valid only with o_pready=1.
REQ-017 o_init_done  out  1  memory clear complete.

Function
REQ-018 FSM states: INIT, IDLE, WAIT, DONE.
REQ-019 INIT: one word per cycle written to zero, index 0 to DEPTH-1; DEPTH cycles total; then IDLE and o_init_done=1 (held until reset).
REQ-020 IDLE: on i_psel=1, i_penable=1, load wait counter with WAIT_STATES; go to WAIT when WAIT_STATES>0, otherwise complete in the same cycle (o_pready=1 combinationally from the counter being zero).
REQ-021 WAIT: counter decrements each cycle; o_pready=0; at counter 0 move to DONE.
REQ-022 DONE: o_pready=1 for exactly one cycle; return to IDLE.
REQ-023 Access valid only if BASE_ADDR <= i_paddr < BASE_ADDR + DEPTH*DATA_W/8 and i_paddr low log2(DATA_W/8) bits are zero; word index = (i_paddr - BASE_ADDR) >> log2(DATA_W/8).
REQ-024 Invalid access: o_pslverr=1 with o_pready; no memory update; o_prdata=0.
REQ-025 Valid write: committed on the rising edge ending the o_pready=1 cycle; only bytes with i_pstrb set change; i_pstrb=0 is a legal no-op, no error.
REQ-026 Valid read: o_prdata = stored word in the o_pready=1 cycle; i_pstrb ignored; o_prdata=0 in all other cycles.
REQ-027 Read of a word written by the immediately preceding transfer SHALL return the new data.
REQ-028 Access presented during INIT: o_pready held 0 until INIT ends, then the access is processed per REQ-020..022 (wait states counted after INIT).
REQ-029 i_psel or i_penable dropping before o_pready (protocol violation): abort to IDLE, no write, no response.
REQ-030 o_pslverr=0 whenever o_pready=0.
REQ-031 Memory is single-ported internally; INIT clear and APB write never occur in the same cycle.

Reset
REQ-032 On i_reset=1, immediately: state=INIT, clear index=0, counter=0, o_pready=0, o_pslverr=0, o_prdata=0, o_init_done=0.
REQ-033 Reset mid-transfer or mid-INIT SHALL abort it; no partial write; clear restarts from index 0 after release.
REQ-034 First clear write occurs on the first rising edge with i_reset=0.

Verification
REQ-035 DEPTH=16, WAIT_STATES=0: release reset -> o_init_done rises after 16 cycles; read of every word returns 0x00000000.
REQ-036 Write 0xDEADBEEF, pstrb=4'b1111 to BASE+0x8; then write 0x11223344, pstrb=4'b0101 to same -> read returns 0xDE22BE44, o_pslverr=0.
REQ-037 WAIT_STATES=2: read access -> o_pready=0 for 2 access cycles, 1 on the 3rd; o_prdata valid only then.
REQ-038 Read BASE+0x40 (DEPTH=16) and BASE+0x2 -> o_pready=1, o_pslverr=1, o_prdata=0; memory unchanged.
REQ-039 Write issued at cycle 3 after reset release -> o_pready stays 0 until o_init_done=1, then completes; readback returns the written value (not cleared).
REQ-040 Assert i_reset during WAIT of a write -> no memory change; o_init_done=0; re-clear completes in DEPTH cycles.
